// File: rtl/aes_ctr_keystream_reorder_if.sv
// Stream bundle between the 3-lane AES-CTR core, the keystream reorder buffer and its consumer.
// The master side drives beats, control and out_ready; the slave side is the reorder buffer.
interface aes_ctr_keystream_reorder_if #(
    parameter int BLOCK_W = 128,
    parameter int LANES   = 3,
    parameter int CTR_W   = 6
);
    logic                       start;
    logic                       mode;
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES-1:0]           in_lane_en;
    logic [LANES*BLOCK_W-1:0]   in_blocks;
    logic [LANES*CTR_W-1:0]     in_ctr;
    logic                       out_valid;
    logic                       out_ready;
    logic [BLOCK_W-1:0]         out_data;
    logic [CTR_W-1:0]           out_idx;
    logic                       done;
    logic                       dup_err;

    modport master (
        output start, mode, in_valid, in_lane_en, in_blocks, in_ctr, out_ready,
        input  in_ready, out_valid, out_data, out_idx, done, dup_err
    );

    modport slave (
        input  start, mode, in_valid, in_lane_en, in_blocks, in_ctr, out_ready,
        output in_ready, out_valid, out_data, out_idx, done, dup_err
    );
endinterface

// File: rtl/aes_ctr_keystream_reorder.sv
// Reorders out-of-order AES-CTR keystream blocks into strict counter order using one
// buffer slot per counter value, and stops after the mode-selected block target.
module aes_ctr_keystream_reorder #(
    parameter int BLOCK_W    = 128,
    parameter int LANES      = 3,
    parameter int CTR_W      = 6,
    parameter int DEPTH      = 48,
    parameter int XOF_BLOCKS = 44,
    parameter int PRF_BLOCKS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    aes_ctr_keystream_reorder_if.slave     bus
);
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [BLOCK_W-1:0]   mem_q [DEPTH];
    logic [BLOCK_W-1:0]   mem_d [DEPTH];
    logic [CTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CTR_W-1:0]     target_q, target_d;
    logic [CTR_W-1:0]     out_idx_q, out_idx_d;
    logic [BLOCK_W-1:0]   out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 dup_err_q, dup_err_d;

    logic [CTR_W-1:0]     lane_ctr  [LANES];
    logic [BLOCK_W-1:0]   lane_data [LANES];
    logic [LANES-1:0]     lane_live;
    logic [LANES-1:0]     lane_hit;
    logic                 in_ready;
    logic                 accept;
    logic                 handshake;
    logic                 dup_hit;
    logic [CTR_W-1:0]     rd_sel;

    // Lane 0 occupies the most significant slice of the packed beat.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_ctr[gi]  = bus.in_ctr[(LANES-1-gi)*CTR_W +: CTR_W];
            assign lane_data[gi] = bus.in_blocks[(LANES-1-gi)*BLOCK_W +: BLOCK_W];
            assign lane_live[gi] = bus.in_lane_en[gi] && (lane_ctr[gi] < target_q);
            assign lane_hit[gi]  = lane_live[gi] && valid_q[lane_ctr[gi]];
        end
    endgenerate

    assign in_ready  = (state_q == S_COLLECT) && !(|lane_hit);
    assign accept    = bus.in_valid && in_ready && !bus.start;
    assign handshake = out_valid_q && bus.out_ready && !bus.start;
    assign rd_sel    = handshake ? (rd_ptr_q + CTR_W'(1)) : rd_ptr_q;

    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (lane_live[i] && lane_live[j] && (lane_ctr[i] == lane_ctr[j])) begin
                    dup_hit = 1'b1;
                end
            end
        end
    end

    // Later lanes overwrite earlier ones, so a duplicate counter keeps the highest lane.
    always_comb begin
        mem_d = mem_q;
        for (int l = 0; l < LANES; l++) begin
            if (accept && lane_live[l]) begin
                mem_d[lane_ctr[l]] = lane_data[l];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        rd_ptr_d    = rd_ptr_q;
        target_d    = target_q;
        dup_err_d   = dup_err_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;

        if (bus.start) begin
            state_d     = S_COLLECT;
            valid_d     = '0;
            rd_ptr_d    = '0;
            dup_err_d   = 1'b0;
            target_d    = bus.mode ? CTR_W'(PRF_BLOCKS) : CTR_W'(XOF_BLOCKS);
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_idx_d   = '0;
        end else begin
            if (state_q == S_COLLECT) begin
                for (int l = 0; l < LANES; l++) begin
                    if (accept && lane_live[l]) begin
                        valid_d[lane_ctr[l]] = 1'b1;
                    end
                end
                if (accept && dup_hit) begin
                    dup_err_d = 1'b1;
                end
                if (handshake) begin
                    valid_d[rd_ptr_q] = 1'b0;
                    rd_ptr_d          = rd_ptr_q + CTR_W'(1);
                    if (rd_ptr_q == target_q - CTR_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            // Output register reloads only when nothing is pending; it looks at the
            // registered valids, which gives the one-edge read latency.
            if (state_d != S_COLLECT) begin
                out_valid_d = 1'b0;
            end else if (!out_valid_q || handshake) begin
                out_valid_d = valid_q[rd_sel];
                out_data_d  = mem_q[rd_sel];
                out_idx_d   = rd_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            rd_ptr_q    <= '0;
            target_q    <= CTR_W'(XOF_BLOCKS);
            dup_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            rd_ptr_q    <= rd_ptr_d;
            target_q    <= target_d;
            dup_err_q   <= dup_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
        end
    end

    // Payload storage carries no reset; slot valids alone decide what is readable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.done      = (state_q == S_DONE);
    assign bus.dup_err   = dup_err_q;
endmodule
